data_mem_stack_unit: RTL
========================

Name: data_mem_stack_unit

Overview:
Parametrised, byte-addressable data memory with an integrated hardware stack, one command port and one response port.
Serves LOAD/STORE for the datapath and PUSH/POP/CALL/RET for stack instructions; owns the stack pointer.
Adds what the previous unit lacked: generic word width and depth, registered 1-cycle responses, a stack limit, and error reporting for overflow, underflow, misalignment and out-of-range accesses.

Parameters:
DATA_W, 32, word width in bits; multiple of 8; WB = DATA_W/8 bytes per word
MEM_BYTES, 1024, memory size in bytes; power of 2, multiple of WB
ADDR_W, 32, width of address and PC ports
SP_INIT, MEM_BYTES, stack pointer reset value (empty stack)
STACK_LIMIT, MEM_BYTES/2, lowest legal SP value; multiple of WB
PC_INC, 1, increment applied to req_pc to form the CALL return address

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  command strobe; one command per cycle, always accepted
req_op  in  3  command: NOP, LOAD, STORE, PUSH, POP, CALL, RET
req_addr  in  ADDR_W  byte address for LOAD/STORE
req_wdata  in  DATA_W  store/push data
req_pc  in  ADDR_W  current PC for CALL
rsp_valid  out  1  one-cycle pulse, one per accepted non-NOP command
rsp_data  out  DATA_W  LOAD/POP data or RET return address; 0 for others and on error
rsp_err  out  3  NONE, OVERFLOW, UNDERFLOW, MISALIGN, RANGE
sp  out  ADDR_W  current stack pointer (zero-extended)

Behaviour:
- Reset (rst_n low at an edge): sp=SP_INIT, rsp_valid=0, rsp_data=0, rsp_err=NONE. Memory array is not cleared. A command presented while rst_n is low is dropped: no write, no response.
- Latency: command accepted at edge N; writes and SP update take effect at edge N; rsp_* valid for the single cycle after edge N.
- Byte order little-endian: word at address A occupies bytes A..A+WB-1, LSB at A.
- Stack is full-descending: sp addresses the top word; sp==SP_INIT means empty.
- LOAD/STORE: if req_addr >= MEM_BYTES, RANGE; else if req_addr mod WB != 0, MISALIGN. On error: no write, rsp_data=0. Errors are not checked against stack bounds, so the stack region is ordinary memory.
- PUSH: if sp-WB < STACK_LIMIT, OVERFLOW: no write, sp unchanged. Else sp <= sp-WB and the word is written at the new sp.
- CALL: as PUSH, with data = req_pc + PC_INC truncated to DATA_W. Same overflow rule.
- POP/RET: if sp == SP_INIT, UNDERFLOW, rsp_data=0, sp unchanged. Else rsp_data = word at sp and sp <= sp+WB. RET differs from POP only in op tag, which is kept for trace.
- Read-after-write: a command at edge N+1 reads data written at edge N. No bypass is needed because the write completes at edge N.
- STORE, PUSH and CALL still pulse rsp_valid (rsp_data=0) so every command is acknowledged.
- NOP or req_valid=0: no response and no state change.
- Arithmetic: sp is held in clog2(MEM_BYTES)+1 bits internally. Comparisons are unsigned, with no wrap-around, because the limit checks precede the update.
- Illegal req_op encodings are treated as NOP.

Decomposition:
- Package mem_stack_pkg holds the op enum (3 bits), the err enum (3 bits) and a helper function for the word byte count.
- One sub-module, byte_lane_ram: MEM_BYTES x 8 array with a WB-wide little-endian word write port and a registered word read port, no reset.
- The top level holds the SP register, the error decode and the response registers.

Test Plan:
(All scenarios use the defaults: DATA_W=32, MEM_BYTES=1024, SP_INIT=1024, STACK_LIMIT=512.)
1. Reset, then STORE 0x100 with 0xDEADBEEF, then LOAD 0x100 on the next cycle -> rsp_data=0xDEADBEEF, err NONE; LOAD 0x101 -> MISALIGN, data 0.
2. PUSH 0x11111111, PUSH 0x22222222 -> sp=1016; POP -> 0x22222222, sp=1020; POP -> 0x11111111, sp=1024; POP -> UNDERFLOW, data 0, sp=1024.
3. CALL with req_pc=0x40 -> sp=1020, word at 1020 = 0x41; RET -> rsp_data=0x41, sp=1024.
4. 128 PUSHes -> sp=512, all NONE; 129th PUSH -> OVERFLOW, sp=512, byte 508 unchanged.
5. LOAD 0x400 -> RANGE; STORE 0x102 with 0xFFFFFFFF -> MISALIGN; LOAD 0x100 still returns 0xDEADBEEF.
6. After 2 PUSHes, assert rst_n low for 1 cycle together with a PUSH -> no rsp, sp=1024; then LOAD 0x3FC -> first pushed value (memory retained).

Source files
------------

// File: rtl/mem_stack_pkg.sv
// Shared types for the data memory / stack unit: command and error tags
// plus the bytes-per-word helper.
package mem_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6
  } mem_op_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_OVERFLOW  = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_MISALIGN  = 3'd3,
    ERR_RANGE     = 3'd4
  } mem_err_e;

  function automatic int unsigned word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Byte-organised RAM: one little-endian word write port and one registered
// word read port. No reset; contents persist across unit resets.
module byte_lane_ram #(
  parameter int unsigned WB        = 4,
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [8*WB-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [8*WB-1:0] rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Word write (LSB at lowest address) and registered word read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < WB; b++) begin
        mem[waddr + AW'(b)] <= wdata[8*b +: 8];
      end
    end
    for (int unsigned b = 0; b < WB; b++) begin
      rdata[8*b +: 8] <= mem[raddr + AW'(b)];
    end
  end

endmodule

// File: rtl/data_mem_stack_unit.sv
// Byte-addressable data memory with an integrated full-descending stack.
// One command per cycle; a registered response follows every non-NOP command.
module data_mem_stack_unit
  import mem_stack_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SP_INIT     = MEM_BYTES,
  parameter int unsigned STACK_LIMIT = MEM_BYTES / 2,
  parameter int unsigned PC_INC      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_err,
  output logic [ADDR_W-1:0] sp
);

  localparam int unsigned WB   = word_bytes(DATA_W);
  localparam int unsigned AW   = $clog2(MEM_BYTES);
  localparam int unsigned SP_W = AW + 1;

  mem_op_e           op;
  logic [SP_W-1:0]   sp_q, sp_nxt, sp_dec;
  logic              rsp_valid_q, rsp_valid_nxt;
  mem_err_e          rsp_err_q, rsp_err_nxt;
  logic              rd_sel_q, rd_sel_nxt;
  logic              we;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] wdata, ram_rdata, call_data;
  logic              addr_range_bad, addr_misaligned, stack_full, stack_empty;

  assign op              = mem_op_e'(req_op);
  assign sp_dec          = sp_q - SP_W'(WB);
  assign call_data       = DATA_W'(req_pc + ADDR_W'(PC_INC));
  assign addr_range_bad  = req_addr >= ADDR_W'(MEM_BYTES);
  assign addr_misaligned = (req_addr % ADDR_W'(WB)) != '0;
  // sp - WB < STACK_LIMIT, rearranged so the subtraction cannot wrap
  assign stack_full      = sp_q < SP_W'(STACK_LIMIT + WB);
  assign stack_empty     = sp_q == SP_W'(SP_INIT);

  // Decode the command into RAM controls, next SP and the pending response.
  always_comb begin
    we            = 1'b0;
    waddr         = req_addr[AW-1:0];
    wdata         = req_wdata;
    raddr         = req_addr[AW-1:0];
    sp_nxt        = sp_q;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = ERR_NONE;
    rd_sel_nxt    = 1'b0;
    if (req_valid) begin
      case (op)
        OP_LOAD, OP_STORE: begin
          rsp_valid_nxt = 1'b1;
          if (addr_range_bad)       rsp_err_nxt = ERR_RANGE;
          else if (addr_misaligned) rsp_err_nxt = ERR_MISALIGN;
          else if (op == OP_LOAD)   rd_sel_nxt  = 1'b1;
          else                      we          = 1'b1;
        end
        OP_PUSH, OP_CALL: begin
          rsp_valid_nxt = 1'b1;
          if (stack_full) begin
            rsp_err_nxt = ERR_OVERFLOW;
          end else begin
            sp_nxt = sp_dec;
            we     = 1'b1;
            waddr  = sp_dec[AW-1:0];
            wdata  = (op == OP_CALL) ? call_data : req_wdata;
          end
        end
        OP_POP, OP_RET: begin
          rsp_valid_nxt = 1'b1;
          if (stack_empty) begin
            rsp_err_nxt = ERR_UNDERFLOW;
          end else begin
            rd_sel_nxt = 1'b1;
            raddr      = sp_q[AW-1:0];
            sp_nxt     = sp_q + SP_W'(WB);
          end
        end
        default: ;
      endcase
    end
  end

  // Stack pointer and response registers; commands during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q        <= SP_W'(SP_INIT);
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_NONE;
      rd_sel_q    <= 1'b0;
    end else begin
      sp_q        <= sp_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rd_sel_q    <= rd_sel_nxt;
    end
  end

  byte_lane_ram #(
    .WB       (WB),
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we & rst_n),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(ram_rdata)
  );

  // The RAM read register already holds the word; only successful reads expose it.
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rd_sel_q ? ram_rdata : '0;
  assign rsp_err   = rsp_err_q;
  assign sp        = ADDR_W'(sp_q);

endmodule
